am_match_counter: RTL and testbench

- Loadable up/down counter that generates the operand stream an equality comparator checks, and performs the stop-on-match function itself.
- Counts from a loaded start value toward a programmed reference word, halts on equality and flags it.
- Used as a microprogram loop or word-count terminator.
- Slice-cascadable through active-low enable-in and carry-out signals.

---
 rtl/am_match_counter.sv | 110 +++++++++++
 tb/tb_am_match_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/am_match_counter.sv
// Loadable up/down counter that stops on equality with a programmed reference word.
// Loads and done_ take effect on the next clk edge; eq_/tc_ are combinational; ein_ high freezes counting.
module am_match_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] d,
    input  logic             load_,
    input  logic             ldref_,
    input  logic             start_,
    input  logic             cnt_en_,
    input  logic             up,
    input  logic             ein_,
    output logic [WIDTH-1:0] q,
    output logic             eq_,
    output logic             tc_,
    output logic             done_,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_MATCH = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] cnt_nxt;
    logic             count_en;

    assign count_en = ~cnt_en_ & ~ein_;
    assign cnt_nxt  = up ? (q_q + ONE) : (q_q - ONE);

    // Match decisions always compare against ref_q, so a same-edge ldref_ sees the old reference.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        ref_d   = ref_q;
        done_d  = done_q;

        if (!ldref_) begin
            ref_d = d;
        end

        if (!load_) begin
            q_d     = d;
            state_d = S_IDLE;
            done_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!start_) begin
                        if (q_q == ref_q) begin
                            state_d = S_MATCH;
                            done_d  = 1'b0;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (count_en) begin
                        q_d = cnt_nxt;
                        if (cnt_nxt == ref_q) begin
                            state_d = S_MATCH;
                            done_d  = 1'b0;
                        end
                    end
                end
                S_MATCH: begin
                    if (!start_) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            ref_q   <= '0;
            done_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            ref_q   <= ref_d;
            done_q  <= done_d;
        end
    end

    assign q     = q_q;
    assign done_ = done_q;
    assign busy  = (state_q == S_RUN);
    assign eq_   = ein_ | (q_q != ref_q);
    assign tc_   = ~(count_en & (up ? (&q_q) : ~(|q_q)));

endmodule

// File: tb/tb_am_match_counter.sv
// Randomized and directed bench for am_match_counter against an arithmetic reference model.
module tb_am_match_counter;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic [7:0] d = 8'h00;
    logic       load_ = 1'b1;
    logic       ldref_ = 1'b1;
    logic       start_ = 1'b1;
    logic       cnt_en_ = 1'b1;
    logic       up = 1'b1;
    logic       ein_ = 1'b0;
    logic [7:0] q;
    logic       eq_, tc_, done_, busy;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Reference model: counter value, reference word and two flags (counting / matched).
    int m_q = 0;
    int m_ref = 0;
    bit m_running = 1'b0;
    bit m_matched = 1'b0;

    am_match_counter #(.WIDTH(8)) dut (
        .clk(clk), .rst_(rst_), .d(d), .load_(load_), .ldref_(ldref_),
        .start_(start_), .cnt_en_(cnt_en_), .up(up), .ein_(ein_),
        .q(q), .eq_(eq_), .tc_(tc_), .done_(done_), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_q = 0; m_ref = 0; m_running = 1'b0; m_matched = 1'b0;
        end else begin
            int old_ref;
            old_ref = m_ref;
            if (!ldref_) m_ref = int'(d);
            if (!load_) begin
                m_q = int'(d); m_running = 1'b0; m_matched = 1'b0;
            end else if (m_matched) begin
                if (!start_) begin m_matched = 1'b0; m_running = 1'b1; end
            end else if (m_running) begin
                if (!cnt_en_ && !ein_) begin
                    m_q = up ? (m_q + 1) % 256 : (m_q + 255) % 256;
                    if (m_q == old_ref) begin m_running = 1'b0; m_matched = 1'b1; end
                end
            end else if (!start_) begin
                if (m_q == old_ref) m_matched = 1'b1;
                else m_running = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_q", q, m_q);
            chk("cyc_done", done_, !m_matched);
            chk("cyc_busy", busy, m_running);
            chk("cyc_eq", eq_, (ein_ || (m_q != m_ref)));
            chk("cyc_tc", tc_, !(!cnt_en_ && !ein_ && (up ? (m_q == 255) : (m_q == 0))));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;
        cmp_on = 1'b1;
        chk("rst_q", q, 8'h00);
        chk("rst_done", done_, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_eq", eq_, 1'b0);

        // Basic count up to 0x05 from 0x02
        d = 8'h05; ldref_ = 1'b0; tick; ldref_ = 1'b1;
        d = 8'h02; load_ = 1'b0; tick; load_ = 1'b1;
        start_ = 1'b0; tick; start_ = 1'b1;
        chk("up_busy_run", busy, 1'b1);
        cnt_en_ = 1'b0; up = 1'b1;
        tick; chk("up_q3", q, 8'h03); chk("model_q3", m_q, 8'h03);
        tick; chk("up_q4", q, 8'h04);
        tick; chk("up_q5", q, 8'h05); chk("up_done", done_, 1'b0); chk("up_busy", busy, 1'b0);
        chk("model_matched", m_matched, 1'b1);
        repeat (4) tick;
        chk("up_hold", q, 8'h05);

        // Down count with wrap to reference 0xFE
        cnt_en_ = 1'b1;
        d = 8'hFE; ldref_ = 1'b0; tick; ldref_ = 1'b1;
        d = 8'h01; load_ = 1'b0; tick; load_ = 1'b1;
        chk("dn_load", q, 8'h01); chk("dn_load_done", done_, 1'b1);
        start_ = 1'b0; tick; start_ = 1'b1;
        cnt_en_ = 1'b0; up = 1'b0;
        tick; chk("dn_q00", q, 8'h00); chk("dn_tc0", tc_, 1'b0);
        tick; chk("dn_qff", q, 8'hFF); chk("dn_tc1", tc_, 1'b1); chk("model_qff", m_q, 255);
        tick; chk("dn_qfe", q, 8'hFE); chk("dn_done", done_, 1'b0); chk("dn_eq", eq_, 1'b0);

        // Start on equal, then re-arm for a full 256-count lap
        cnt_en_ = 1'b1;
        d = 8'h10; ldref_ = 1'b0; load_ = 1'b0; tick; ldref_ = 1'b1; load_ = 1'b1;
        chk("both_q", q, 8'h10); chk("both_eq", eq_, 1'b0);
        start_ = 1'b0; tick; start_ = 1'b1;
        chk("se_done", done_, 1'b0); chk("se_busy", busy, 1'b0); chk("se_q", q, 8'h10);
        up = 1'b1; start_ = 1'b0; tick; start_ = 1'b1;
        chk("rearm_done", done_, 1'b1); chk("rearm_busy", busy, 1'b1); chk("rearm_q", q, 8'h10);
        cnt_en_ = 1'b0;
        tick; chk("lap_q11", q, 8'h11);
        repeat (254) tick;
        chk("lap_q0f", q, 8'h0F); chk("lap_done_hi", done_, 1'b1);
        tick; chk("lap_q10", q, 8'h10); chk("lap_done_lo", done_, 1'b0);

        // load_ wins over start_ on the same edge
        cnt_en_ = 1'b1;
        d = 8'h33; load_ = 1'b0; start_ = 1'b0; tick; load_ = 1'b1; start_ = 1'b1;
        chk("ls_q", q, 8'h33); chk("ls_busy", busy, 1'b0); chk("ls_done", done_, 1'b1);
        tick; chk("ls_busy2", busy, 1'b0);

        // Reference reload on the matching edge uses the old reference
        d = 8'h20; ldref_ = 1'b0; tick; ldref_ = 1'b1;
        d = 8'h1F; load_ = 1'b0; tick; load_ = 1'b1;
        start_ = 1'b0; tick; start_ = 1'b1;
        cnt_en_ = 1'b0; up = 1'b1; d = 8'h40; ldref_ = 1'b0; tick; ldref_ = 1'b1; cnt_en_ = 1'b1;
        chk("oref_q", q, 8'h20); chk("oref_done", done_, 1'b0); chk("oref_eq", eq_, 1'b1);

        // Cascade enable freezes counting and masks eq_/tc_
        d = 8'h50; ldref_ = 1'b0; tick; ldref_ = 1'b1;
        d = 8'h4E; load_ = 1'b0; tick; load_ = 1'b1;
        start_ = 1'b0; tick; start_ = 1'b1;
        cnt_en_ = 1'b0; ein_ = 1'b1;
        repeat (3) tick;
        chk("ein_hold", q, 8'h4E); chk("ein_busy", busy, 1'b1);
        ein_ = 1'b0;
        tick; chk("ein_q4f", q, 8'h4F);
        tick; chk("ein_q50", q, 8'h50); chk("ein_done", done_, 1'b0);
        ein_ = 1'b1; #1 chk("ein_eq_mask", eq_, 1'b1);
        ein_ = 1'b0; #1 chk("ein_eq_live", eq_, 1'b0);
        cnt_en_ = 1'b1;
        d = 8'hFF; load_ = 1'b0; tick; load_ = 1'b1;
        cnt_en_ = 1'b0; up = 1'b1; ein_ = 1'b1; #1 chk("tc_mask", tc_, 1'b1);
        ein_ = 1'b0; #1 chk("tc_ones", tc_, 1'b0);
        cnt_en_ = 1'b1; #1 chk("tc_noen", tc_, 1'b1);

        // Asynchronous reset mid-run at q=0x37
        d = 8'h99; ldref_ = 1'b0; tick; ldref_ = 1'b1;
        d = 8'h37; load_ = 1'b0; tick; load_ = 1'b1;
        start_ = 1'b0; tick; start_ = 1'b1;
        chk("ar_busy_pre", busy, 1'b1); chk("ar_q_pre", q, 8'h37);
        #2 rst_ = 1'b0;
        #1 chk("ar_q", q, 8'h00); chk("ar_done", done_, 1'b1); chk("ar_busy", busy, 1'b0);
        @(posedge clk); #1 rst_ = 1'b1;

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 4000; i++) begin
            d       = 8'($urandom_range(0, 255));
            load_   = ($urandom_range(0, 15) != 0);
            ldref_  = ($urandom_range(0, 23) != 0);
            start_  = ($urandom_range(0, 7) != 0);
            cnt_en_ = ($urandom_range(0, 3) == 0);
            ein_    = ($urandom_range(0, 7) == 0);
            up      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_ = 1'b0;
                #1 chk("rnd_rst_q", q, 8'h00); chk("rnd_rst_busy", busy, 1'b0);
                @(posedge clk); #1 rst_ = 1'b1;
            end else begin
                tick;
            end
        end

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
